dsc_mul_seq: RTL and testbench

DSC_MUL_SEQ -- requirements
Module: dsc_mul_seq

---
 rtl/dsc_pkg.sv | 15 +
 rtl/dsc_mul_seq_if.sv | 36 +++
 rtl/dsc_seq_wdog.sv | 27 ++
 rtl/dsc_mul_seq.sv | 114 +++++++++++
 tb/tb_dsc_mul_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/dsc_pkg.sv
// Shared constants and FSM state type for the dsc_mul sequencer.
package dsc_pkg;

  localparam int unsigned SngWidthDefault = 4;
  // Extra RUN cycles tolerated beyond the nominal 2^(2W) before the watchdog fires.
  localparam int unsigned TimeoutMargin = 4;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } seq_state_e;

endpackage

// File: rtl/dsc_mul_seq_if.sv
// Operand/result handshake and multiplier control bundle for dsc_mul_seq.
interface dsc_mul_seq_if
  import dsc_pkg::*;
#(
  parameter int unsigned SNG_WIDTH = SngWidthDefault
);

  logic                   in_valid;
  logic                   in_ready;
  logic [SNG_WIDTH-1:0]   in_a;
  logic [SNG_WIDTH-1:0]   in_b;
  logic [SNG_WIDTH-1:0]   mul_a;
  logic [SNG_WIDTH-1:0]   mul_b;
  logic                   mul_en;
  logic                   mul_rst;
  logic [2*SNG_WIDTH-1:0] mul_z;
  logic                   mul_ov;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*SNG_WIDTH-1:0] out_z;
  logic                   busy;
  logic                   err;

  // Environment side: operand source, result sink and the attached multiplier.
  modport master (
    output in_valid, in_a, in_b, out_ready, mul_z, mul_ov,
    input  in_ready, mul_a, mul_b, mul_en, mul_rst, out_valid, out_z, busy, err
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_z, mul_ov,
    output in_ready, mul_a, mul_b, mul_en, mul_rst, out_valid, out_z, busy, err
  );

endinterface

// File: rtl/dsc_seq_wdog.sv
// RUN-cycle watchdog: counts while run is high, clears otherwise, flags on reaching Limit.
module dsc_seq_wdog #(
  parameter int unsigned CntWidth = 9,
  parameter int unsigned Limit    = 260
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  logic [CntWidth-1:0] cnt_q;

  assign expired = (cnt_q == CntWidth'(Limit));

  // Saturate at the terminal count so the flag cannot wrap away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dsc_mul_seq.sv
// Sequencer for one dsc_mul product: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
// Optional RUN watchdog enabled by defining DSC_SEQ_TIMEOUT_EN.
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int unsigned SNG_WIDTH = SngWidthDefault
) (
  input  logic          clk,
  input  logic          rst,
  dsc_mul_seq_if.slave  bus
);

  localparam int unsigned ZW = 2 * SNG_WIDTH;

  seq_state_e           state_q, state_d;
  logic [SNG_WIDTH-1:0] mul_a_q, mul_a_d;
  logic [SNG_WIDTH-1:0] mul_b_q, mul_b_d;
  logic [ZW-1:0]        out_z_q, out_z_d;
  logic                 first_q, first_d;
  logic                 ov_hit;
  logic                 timeout;

  // The multiplier's ov may still be high from the previous product on RUN entry.
  assign ov_hit = !first_q && bus.mul_ov;

  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    out_z_d = out_z_q;
    first_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mul_a_d = bus.in_a;
          mul_b_d = bus.in_b;
          state_d = StClear;
        end
      end
      StClear: begin
        first_d = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (ov_hit) begin
          out_z_d = bus.mul_z;
          state_d = StDone;
        end else if (timeout) begin
          out_z_d = '1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mul_a_q <= '0;
      mul_b_q <= '0;
      out_z_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      out_z_q <= out_z_d;
      first_q <= first_d;
    end
  end

`ifdef DSC_SEQ_TIMEOUT_EN
  logic err_q;

  dsc_seq_wdog #(
    .CntWidth (ZW + 1),
    .Limit    ((1 << ZW) + TimeoutMargin)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == StRun),
    .expired (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == StRun) && !ov_hit && timeout) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.mul_en    = (state_q == StRun);
  assign bus.out_valid = (state_q == StDone);
  assign bus.mul_rst   = rst | (state_q == StClear);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_z     = out_z_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Self-checking bench for dsc_mul_seq with a behavioural unary-count multiplier stub.
// Timeout scenario is exercised only when DSC_SEQ_TIMEOUT_EN is defined.
module tb_dsc_mul_seq;
  import dsc_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned ZW = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsc_mul_seq_if #(.SNG_WIDTH(W)) bus ();

  dsc_mul_seq #(.SNG_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub multiplier: walks all 2^(2W) (i,j) pairs, counting i<a && j<b; ov when done.
  int          stub_mode = 0;  // 0 normal, 2 never asserts ov
  logic        force_ov  = 1'b0;
  logic [ZW:0] m_cnt;
  logic [ZW-1:0] m_z;

  always @(posedge clk) begin
    if (bus.mul_rst) begin
      m_cnt <= '0;
      m_z   <= '0;
    end else if (bus.mul_en && !m_cnt[ZW]) begin
      if ((m_cnt[W-1:0] < bus.mul_a) && (m_cnt[2*W-1:W] < bus.mul_b)) m_z <= m_z + 1'b1;
      m_cnt <= m_cnt + 1'b1;
    end
  end

  assign bus.mul_z  = m_z;
  assign bus.mul_ov = (stub_mode == 2) ? 1'b0 : (force_ov | m_cnt[ZW]);

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset();
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_mul_en", 32'(bus.mul_en), 32'd0);
    check_val("rst_mul_a", 32'(bus.mul_a), 32'd0);
    check_val("rst_mul_b", 32'(bus.mul_b), 32'd0);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_z", 32'(bus.out_z), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    check_val("rst_mul_rst", 32'(bus.mul_rst), 32'd1);
  endtask

  // Offer one operand pair from IDLE; returns once CLEAR is visible.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    @(negedge clk);
    check_val("idle_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_val("clear_mul_rst", 32'(bus.mul_rst), 32'd1);
    check_val("clear_mul_en", 32'(bus.mul_en), 32'd0);
    check_val("clear_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // Wait (bounded) for out_valid while throwing stray offers at the busy sequencer.
  task automatic wait_done(input int start_n, output int n);
    n = start_n;
    while (!bus.out_valid && n < 400) begin
      @(negedge clk);
      n++;
      bus.in_valid = 1'($urandom);
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
    end
    bus.in_valid = 1'b0;
    check_val("done_seen", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [ZW-1:0] exp_z, input int stall);
    check_val("out_z", 32'(bus.out_z), 32'(exp_z));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      @(negedge clk);
      check_val("bp_valid", 32'(bus.out_valid), 32'd1);
      check_val("bp_z", 32'(bus.out_z), 32'(exp_z));
      check_val("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    check_val("held_a", 32'(bus.mul_a), 32'(a));
    check_val("held_b", 32'(bus.mul_b), 32'(b));
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val("ret_valid", 32'(bus.out_valid), 32'd0);
    check_val("ret_ready", 32'(bus.in_ready), 32'd1);
    check_val("ret_busy", 32'(bus.busy), 32'd0);
  endtask

  // CLEAR is n=1, RUN spans 2^(2W)..2^(2W)+2 cycles, so DONE first appears at n in [258,260].
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    int n;
    logic [ZW-1:0] exp_z;
    exp_z = ZW'(int'(a) * int'(b));
    accept(a, b, stall == 0);
    wait_done(1, n);
    check_val("latency", 32'(n >= 258 && n <= 260), 32'd1);
    finish_op(a, b, exp_z, stall);
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    #1 rst = 1'b1;
    #1 check_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed operands, including zero and full-scale extremes.
    run_op(4'd3, 4'd5, 0);
    run_op(4'd0, 4'd9, 0);
    run_op(4'd15, 4'd15, 0);
    run_op(4'd15, 4'd1, 0);

    // Long backpressure with stray offers during DONE.
    run_op(4'd7, 4'd13, 50);

    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
    end

    // Abort mid-RUN, then a fresh product.
    accept(4'd9, 4'd9, 1'b1);
    repeat (100) @(negedge clk);
    check_val("midrun_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset();
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd2, 4'd7, 0);

    // ov still high on RUN entry must not be taken as completion.
    force_ov = 1'b1;
    accept(4'd6, 4'd11, 1'b1);
    @(negedge clk);
    check_val("stale_run_en", 32'(bus.mul_en), 32'd1);
    force_ov = 1'b0;
    @(negedge clk);
    check_val("stale_no_capture", 32'(bus.out_valid), 32'd0);
    check_val("stale_busy", 32'(bus.busy), 32'd1);
    wait_done(3, n);
    check_val("stale_latency", 32'(n >= 258 && n <= 260), 32'd1);
    finish_op(4'd6, 4'd11, 8'd66, 0);

`ifdef DSC_SEQ_TIMEOUT_EN
    // Multiplier never completes: watchdog fires at RUN cycle 2^(2W)+4.
    stub_mode = 2;
    accept(4'd5, 4'd5, 1'b1);
    wait_done(1, n);
    check_val("to_latency", 32'(n), 32'd263);
    check_val("to_err", 32'(bus.err), 32'd1);
    finish_op(4'd5, 4'd5, 8'hFF, 2);
    check_val("to_err_sticky", 32'(bus.err), 32'd1);
    stub_mode = 0;
    run_op(4'd3, 4'd3, 0);
    check_val("to_err_still", 32'(bus.err), 32'd1);
    #2 rst = 1'b1;
    #1 check_val("to_err_cleared", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    check_val("err_tied", 32'(bus.err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
